// File: rtl/sid_write_arbiter.sv
// Two-requester write arbiter for the SID voice register set.
// Requester A (SPI host) and B (autoplay sequencer) write addr/data over
// valid/ready; ownership can be locked for bursts and drops on idle timeout.
// Each requester has its own frequency low-byte stage for atomic 16-bit commits.
module sid_write_arbiter #(
    parameter bit          FIXED_PRIO_A = 1'b0,
    parameter int unsigned LOCK_TIMEOUT = 16,
    parameter int unsigned TO_W         = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_addr,
    input  logic [7:0]  a_data,
    input  logic        a_lock,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [2:0]  b_addr,
    input  logic [7:0]  b_data,
    input  logic        b_lock,
    output logic [15:0] sid_frequency,
    output logic [7:0]  sid_duration,
    output logic [7:0]  sid_attack,
    output logic [7:0]  sid_sustain,
    output logic [7:0]  sid_waveform,
    output logic [7:0]  v2_attack,
    output logic [7:0]  v2_gate_freq,
    output logic [1:0]  owner,
    output logic        wr_strobe
);

    // State encoding doubles as the owner code.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOCK_A = 2'b01;
    localparam logic [1:0] ST_LOCK_B = 2'b10;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    logic [1:0]      state;
    logic            prio_b;  // 1: B is favoured on the next contested IDLE cycle
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      stage_a;
    logic [7:0]      stage_b;

    logic            gnt_a;
    logic            gnt_b;
    logic            wr_en;
    logic [2:0]      w_addr;
    logic [7:0]      w_data;
    logic [7:0]      w_stage;
    logic            own_valid;
    logic            own_lock;

    // Combinational grant; never asserted without valid or during reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            case (state)
                ST_LOCK_A: gnt_a = a_valid;
                ST_LOCK_B: gnt_b = b_valid;
                default: begin
                    if (a_valid && b_valid) begin
                        if (FIXED_PRIO_A || !prio_b) gnt_a = 1'b1;
                        else                         gnt_b = 1'b1;
                    end else begin
                        gnt_a = a_valid;
                        gnt_b = b_valid;
                    end
                end
            endcase
        end
    end

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign wr_en     = gnt_a | gnt_b;
    assign w_addr    = gnt_b ? b_addr  : a_addr;
    assign w_data    = gnt_b ? b_data  : a_data;
    assign w_stage   = gnt_b ? stage_b : stage_a;
    assign own_valid = (state == ST_LOCK_B) ? b_valid : a_valid;
    assign own_lock  = (state == ST_LOCK_B) ? b_lock  : a_lock;
    assign owner     = state;

    // Arbitration state: lock FSM, round-robin pointer and idle timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            prio_b <= 1'b0;
            to_cnt <= '0;
        end else begin
            if (gnt_a)      prio_b <= 1'b1;
            else if (gnt_b) prio_b <= 1'b0;
            case (state)
                ST_LOCK_A, ST_LOCK_B: begin
                    if (own_valid) begin
                        to_cnt <= '0;
                        if (!own_lock) state <= ST_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    to_cnt <= '0;
                    if (gnt_a && a_lock)      state <= ST_LOCK_A;
                    else if (gnt_b && b_lock) state <= ST_LOCK_B;
                    else                      state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file update from the granted beat, plus the write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_a       <= '0;
            stage_b       <= '0;
            sid_frequency <= '0;
            sid_duration  <= '0;
            sid_attack    <= '0;
            sid_sustain   <= '0;
            sid_waveform  <= '0;
            v2_attack     <= '0;
            v2_gate_freq  <= '0;
            wr_strobe     <= 1'b0;
        end else begin
            wr_strobe <= wr_en;
            if (wr_en) begin
                case (w_addr)
                    3'd0: begin
                        if (gnt_b) stage_b <= w_data;
                        else       stage_a <= w_data;
                    end
                    3'd1: sid_frequency <= {w_data, w_stage};
                    3'd2: sid_duration  <= w_data;
                    3'd3: v2_attack     <= w_data;
                    3'd4: sid_attack    <= w_data;
                    3'd5: sid_sustain   <= w_data;
                    3'd6: sid_waveform  <= w_data;
                    3'd7: v2_gate_freq  <= w_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Directed bench for sid_write_arbiter: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_sid_write_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_lock, b_valid, b_lock;
    logic [2:0]  a_addr, b_addr;
    logic [7:0]  a_data, b_data;

    logic        a_ready, b_ready, wr_strobe;
    logic [15:0] sid_frequency;
    logic [7:0]  sid_duration, sid_attack, sid_sustain, sid_waveform, v2_attack, v2_gate_freq;
    logic [1:0]  owner;

    logic        fp_a_ready, fp_b_ready, fp_wr_strobe;
    logic [15:0] fp_frequency;
    logic [7:0]  fp_duration, fp_attack, fp_sustain, fp_waveform, fp_v2_attack, fp_v2_gate;
    logic [1:0]  fp_owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sid_write_arbiter #(.FIXED_PRIO_A(1'b0), .LOCK_TIMEOUT(TO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_lock(b_lock),
        .sid_frequency(sid_frequency), .sid_duration(sid_duration), .sid_attack(sid_attack),
        .sid_sustain(sid_sustain), .sid_waveform(sid_waveform), .v2_attack(v2_attack),
        .v2_gate_freq(v2_gate_freq), .owner(owner), .wr_strobe(wr_strobe)
    );

    sid_write_arbiter #(.FIXED_PRIO_A(1'b1), .LOCK_TIMEOUT(TO), .TO_W(5)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_data(a_data),
        .a_lock(a_lock),
        .b_valid(b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_data(b_data),
        .b_lock(b_lock),
        .sid_frequency(fp_frequency), .sid_duration(fp_duration), .sid_attack(fp_attack),
        .sid_sustain(fp_sustain), .sid_waveform(fp_waveform), .v2_attack(fp_v2_attack),
        .v2_gate_freq(fp_v2_gate), .owner(fp_owner), .wr_strobe(fp_wr_strobe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, sample readies/owner mid-cycle, return 1 after the edge.
    task automatic beat(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                        input logic al, input logic bv, input logic [2:0] ba,
                        input logic [7:0] bd, input logic bl,
                        output logic ga, output logic gb, output logic [1:0] ow);
        a_valid = av; a_addr = aa; a_data = ad; a_lock = al;
        b_valid = bv; b_addr = ba; b_data = bd; b_lock = bl;
        #2;
        ga = a_ready; gb = b_ready; ow = owner;
        @(posedge clk);
        #1;
    endtask

    logic       ga, gb;
    logic [1:0] ow;

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 8'hFF; a_lock = 1'b1;
        b_valid = 1'b1; b_addr = 3'd1; b_data = 8'hFF; b_lock = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_fp_a_ready", fp_a_ready, 0);
        check("rst_freq", sid_frequency, 0);
        check("rst_dur", sid_duration, 0);
        check("rst_outs_or", {sid_attack | sid_sustain | sid_waveform | v2_attack | v2_gate_freq},
              0);
        check("rst_owner", owner, 0);
        check("rst_strobe", wr_strobe, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;

        // Idle: no ready without valid
        beat(0, 0, 0, 0, 0, 0, 0, 0, ga, gb, ow);
        check("idle_ready", {ga, gb}, 0);

        // Atomic frequency from A's stage
        beat(1, 0, 8'h34, 0, 0, 0, 0, 0, ga, gb, ow);
        check("freq_lo_gnt", ga, 1);
        check("freq_lo_hold", sid_frequency, 16'h0000);
        check("freq_lo_strobe", wr_strobe, 1);
        beat(1, 1, 8'h12, 0, 0, 0, 0, 0, ga, gb, ow);
        check("freq_commit", sid_frequency, 16'h1234);
        check("freq_hi_strobe", wr_strobe, 1);
        beat(0, 0, 0, 0, 0, 0, 0, 0, ga, gb, ow);
        check("strobe_drop", wr_strobe, 0);

        // Interleaved stages
        beat(1, 0, 8'hAA, 0, 0, 0, 0, 0, ga, gb, ow);
        beat(0, 0, 0, 0, 1, 0, 8'h55, 0, ga, gb, ow);
        check("il_b_stage_gnt", gb, 1);
        beat(0, 0, 0, 0, 1, 1, 8'h01, 0, ga, gb, ow);
        check("il_b_freq", sid_frequency, 16'h0155);
        beat(1, 1, 8'h02, 0, 0, 0, 0, 0, ga, gb, ow);
        check("il_a_freq", sid_frequency, 16'h02AA);

        // Stage reuse: B commits again with its retained 0x55
        beat(0, 0, 0, 0, 1, 1, 8'h07, 0, ga, gb, ow);
        check("stage_reuse", sid_frequency, 16'h0755);

        // Round robin: last grant was B, so A is favoured first
        for (int i = 1; i <= 4; i++) begin
            beat(1, 2, 8'(i), 0, 1, 2, 8'(8'h10 + i), 0, ga, gb, ow);
            check($sformatf("rr_gnt%0d", i), {ga, gb}, (i % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr_dur%0d", i), sid_duration, (i % 2 == 1) ? i : 8'h10 + i);
        end

        // Fixed priority instance saw the same four cycles
        check("fp_dur", fp_duration, 8'h04);

        // Lock: B burst, A contending from the second beat
        beat(0, 0, 0, 0, 1, 4, 8'h41, 1, ga, gb, ow);
        check("lk_b1_gnt", gb, 1);
        check("lk_owner1", owner, 2'b10);
        beat(1, 7, 8'h99, 0, 1, 5, 8'h51, 1, ga, gb, ow);
        check("lk_b2_gnt", {ga, gb}, 2'b01);
        check("lk_owner_mid", ow, 2'b10);
        beat(1, 7, 8'h99, 0, 1, 6, 8'h61, 0, ga, gb, ow);
        check("lk_b3_gnt", {ga, gb}, 2'b01);
        check("lk_owner_end", owner, 2'b00);
        beat(1, 7, 8'h99, 0, 0, 0, 0, 0, ga, gb, ow);
        check("lk_a_after", ga, 1);
        check("lk_regs", {sid_attack, sid_sustain, sid_waveform, v2_gate_freq}, 32'h41516199);

        // Timeout: B locks then goes quiet
        beat(0, 0, 0, 0, 1, 2, 8'hEE, 1, ga, gb, ow);
        check("to_owner", owner, 2'b10);
        for (int k = 0; k < TO; k++) begin
            beat(1, 3, 8'h33, 0, 0, 0, 0, 0, ga, gb, ow);
            check($sformatf("to_wait%0d", k), {ow, ga}, 3'b100);
        end
        beat(1, 3, 8'h33, 0, 0, 0, 0, 0, ga, gb, ow);
        check("to_release", {ow, ga}, 3'b001);
        check("to_v2_attack", v2_attack, 8'h33);

        // Reset mid-lock and mid-stage
        beat(0, 0, 0, 0, 1, 0, 8'hC3, 1, ga, gb, ow);
        check("mr_owner", owner, 2'b10);
        rst_n = 1'b0;
        beat(0, 0, 0, 0, 1, 1, 8'h3C, 0, ga, gb, ow);
        check("mr_no_gnt", gb, 0);
        check("mr_owner_clr", owner, 0);
        check("mr_freq_clr", sid_frequency, 0);
        rst_n = 1'b1;
        beat(0, 0, 0, 0, 1, 1, 8'h3C, 0, ga, gb, ow);
        check("mr_stage_clr", sid_frequency, 16'h3C00);
        beat(0, 0, 0, 0, 0, 0, 0, 0, ga, gb, ow);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Fixed-priority instance: A wins every contested cycle of the RR sequence.
    initial begin
        @(posedge rst_n);
        wait (a_valid && b_valid && a_addr == 3'd2 && b_addr == 3'd2);
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("fp_gnt%0d", j), {fp_a_ready, fp_b_ready}, 2'b10);
            @(posedge clk);
            #1;
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end

endmodule
